// File: rtl/decode_pkg.sv
// Shared mode constants and the one-hot decode used by the sequenced and dataflow decoders.
// Pure definitions; no state, no latency.
package decode_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_SEL_W = 6;
    localparam int MAX_OUT   = 2**MAX_SEL_W;

    // Callers size-cast the result down to their own 2**SEL_W lines.
    function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_OUT-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Scan prescaler: counts 0..PERIOD-1 while run is high; tick marks the terminal count.
// tick is combinational from the count register; no backpressure, clear overrides run.
module tick_gen #(
    parameter int PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(PERIOD + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(PERIOD - 1));
    assign tick   = run & w_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/decode_nto2n_seq.sv
// Registered N-to-2^N decoder with direct load and prescaled scan of the index.
// All outputs one cycle after the deciding edge; no backpressure, enable=0 blanks and freezes.
module decode_nto2n_seq
    import decode_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int PERIOD     = 4,
    parameter bit ACTIVE_LOW = 1'b0,
    localparam int N_OUT     = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             load,
    output logic [N_OUT-1:0] out,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    logic [SEL_W-1:0] r_idx;
    logic [N_OUT-1:0] r_out;
    logic             r_wrap;

    logic             w_run;
    logic             w_clear;
    logic             w_tick;
    logic [SEL_W-1:0] w_idx_nxt;
    logic [N_OUT-1:0] w_dec_sel;
    logic [N_OUT-1:0] w_dec_cur;
    logic [N_OUT-1:0] w_dec_nxt;
    logic [N_OUT-1:0] w_inactive;

    // Prescaler is frozen while blanked, zeroed on load and throughout DIRECT mode.
    assign w_run   = enable & ~load & (mode == MODE_SCAN);
    assign w_clear = enable & (load | (mode == MODE_DIRECT));

    tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .run   (w_run),
        .clear (w_clear),
        .tick  (w_tick)
    );

    assign w_idx_nxt  = r_idx + SEL_W'(1);
    assign w_dec_sel  = N_OUT'(onehot(MAX_SEL_W'(sel)));
    assign w_dec_cur  = N_OUT'(onehot(MAX_SEL_W'(r_idx)));
    assign w_dec_nxt  = N_OUT'(onehot(MAX_SEL_W'(w_idx_nxt)));
    assign w_inactive = ACTIVE_LOW ? {N_OUT{1'b1}} : {N_OUT{1'b0}};

    function automatic logic [N_OUT-1:0] polar(input logic [N_OUT-1:0] v);
        return ACTIVE_LOW ? ~v : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_out  <= w_inactive;
            r_wrap <= 1'b0;
        end else if (!enable) begin
            r_out  <= w_inactive;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_idx  <= sel;
            r_out  <= polar(w_dec_sel);
            r_wrap <= 1'b0;
        end else if (w_tick) begin
            r_idx  <= w_idx_nxt;
            r_out  <= polar(w_dec_nxt);
            r_wrap <= &r_idx;
        end else begin
            r_out  <= polar(w_dec_cur);
            r_wrap <= 1'b0;
        end
    end

    assign out  = r_out;
    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_decode_nto2n_seq.sv
// Directed checks of three decoder configurations sharing one clock.
module tb_decode_nto2n_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // A: SEL_W=2, PERIOD=3, active-high
    logic       a_rst = 1'b1, a_en = 1'b0, a_mode = 1'b0, a_load = 1'b0;
    logic [1:0] a_sel = '0;
    logic [3:0] a_out;
    logic [1:0] a_idx;
    logic       a_wrap;

    // B: SEL_W=3, PERIOD=4, active-low
    logic       b_rst = 1'b1, b_en = 1'b0, b_mode = 1'b0, b_load = 1'b0;
    logic [2:0] b_sel = '0;
    logic [7:0] b_out;
    logic [2:0] b_idx;
    logic       b_wrap;

    // C: SEL_W=3, PERIOD=1, active-high
    logic       c_rst = 1'b1, c_en = 1'b0, c_mode = 1'b0, c_load = 1'b0;
    logic [2:0] c_sel = '0;
    logic [7:0] c_out;
    logic [2:0] c_idx;
    logic       c_wrap;

    decode_nto2n_seq #(.SEL_W(2), .PERIOD(3), .ACTIVE_LOW(1'b0)) u_a (
        .clk(clk), .rst(a_rst), .enable(a_en), .mode(a_mode), .sel(a_sel),
        .load(a_load), .out(a_out), .idx(a_idx), .wrap(a_wrap)
    );

    decode_nto2n_seq #(.SEL_W(3), .PERIOD(4), .ACTIVE_LOW(1'b1)) u_b (
        .clk(clk), .rst(b_rst), .enable(b_en), .mode(b_mode), .sel(b_sel),
        .load(b_load), .out(b_out), .idx(b_idx), .wrap(b_wrap)
    );

    decode_nto2n_seq #(.SEL_W(3), .PERIOD(1), .ACTIVE_LOW(1'b0)) u_c (
        .clk(clk), .rst(c_rst), .enable(c_en), .mode(c_mode), .sel(c_sel),
        .load(c_load), .out(c_out), .idx(c_idx), .wrap(c_wrap)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_a(input string tag, input logic [3:0] e_out, input logic [1:0] e_idx,
                         input logic e_wrap);
        chk({tag, ".out"},  64'(a_out),  64'(e_out));
        chk({tag, ".idx"},  64'(a_idx),  64'(e_idx));
        chk({tag, ".wrap"}, 64'(a_wrap), 64'(e_wrap));
    endtask

    task automatic chk_b(input string tag, input logic [7:0] e_out, input logic [2:0] e_idx,
                         input logic e_wrap);
        chk({tag, ".out"},  64'(b_out),  64'(e_out));
        chk({tag, ".idx"},  64'(b_idx),  64'(e_idx));
        chk({tag, ".wrap"}, 64'(b_wrap), 64'(e_wrap));
    endtask

    initial begin
        logic [1:0] e2;
        logic [2:0] e3;

        step();
        chk_a("a_reset", 4'b0000, 2'd0, 1'b0);

        // Enable low after reset keeps lines inactive
        a_rst = 1'b0;
        step();
        chk_a("a_post_reset_blank", 4'b0000, 2'd0, 1'b0);

        // Direct load of sel=2, then hold
        a_en = 1'b1; a_mode = 1'b0; a_load = 1'b1; a_sel = 2'd2;
        step();
        chk_a("a_load2", 4'b0100, 2'd2, 1'b0);
        a_load = 1'b0; a_sel = 2'd1;
        step();
        chk_a("a_hold1", 4'b0100, 2'd2, 1'b0);
        step();
        chk_a("a_hold2", 4'b0100, 2'd2, 1'b0);

        // Scan from idx=0: a step every 3 cycles, wrap on 3->0
        a_load = 1'b1; a_sel = 2'd0;
        step();
        chk_a("a_load0", 4'b0001, 2'd0, 1'b0);
        a_load = 1'b0; a_mode = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            for (int c = 0; c < 3; c++) begin
                step();
                e2 = (c == 2) ? 2'(s) : 2'(s - 1);
                chk_a($sformatf("a_scan_s%0d_c%0d", s, c), 4'(4'b0001 << e2), e2,
                      (c == 2) && (s == 4));
            end
        end

        // Load sel=3 on the edge where a step was due
        step();
        step();
        chk_a("a_pre_load_coincide", 4'b0001, 2'd0, 1'b0);
        a_load = 1'b1; a_sel = 2'd3;
        step();
        chk_a("a_load_coincide", 4'b1000, 2'd3, 1'b0);
        a_load = 1'b0;
        step();
        step();
        chk_a("a_after_load_2cyc", 4'b1000, 2'd3, 1'b0);
        step();
        chk_a("a_after_load_step", 4'b0001, 2'd0, 1'b1);

        // Blank for 5 cycles with prescaler at 1, then resume
        step();
        chk_a("a_pre_blank", 4'b0001, 2'd0, 1'b0);
        a_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_a($sformatf("a_blank%0d", i), 4'b0000, 2'd0, 1'b0);
        end
        a_en = 1'b1;
        step();
        chk_a("a_unblank", 4'b0001, 2'd0, 1'b0);
        step();
        chk_a("a_resume_step", 4'b0010, 2'd1, 1'b0);

        // SCAN->DIRECT freezes idx; DIRECT->SCAN restarts prescaler at 0
        a_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a($sformatf("a_direct_freeze%0d", i), 4'b0010, 2'd1, 1'b0);
        end
        a_mode = 1'b1;
        step();
        step();
        chk_a("a_rescan_2cyc", 4'b0010, 2'd1, 1'b0);
        step();
        chk_a("a_rescan_step", 4'b0100, 2'd2, 1'b0);

        // B: active-low, reset mid-scan at idx=5
        chk_b("b_reset", 8'hFF, 3'd0, 1'b0);
        b_rst = 1'b0; b_en = 1'b1; b_mode = 1'b1; b_load = 1'b1; b_sel = 3'd4;
        step();
        chk_b("b_load4", 8'hEF, 3'd4, 1'b0);
        b_load = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk_b("b_step5", 8'hDF, 3'd5, 1'b0);
        step();
        step();
        b_rst = 1'b1;
        step();
        chk_b("b_mid_reset", 8'hFF, 3'd0, 1'b0);
        b_rst = 1'b0; b_en = 1'b0;
        step();
        chk_b("b_post_reset_blank", 8'hFF, 3'd0, 1'b0);
        b_en = 1'b1;
        step();
        chk_b("b_first_enable", 8'hFE, 3'd0, 1'b0);

        // C: PERIOD=1 walks every cycle
        chk("c_reset.out", 64'(c_out), 64'h0);
        c_rst = 1'b0; c_en = 1'b1; c_mode = 1'b1; c_load = 1'b1; c_sel = 3'd0;
        step();
        chk("c_load0.out", 64'(c_out), 64'h01);
        c_load = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            e3 = 3'(i);
            chk($sformatf("c_walk%0d.idx", i),  64'(c_idx),  64'(e3));
            chk($sformatf("c_walk%0d.out", i),  64'(c_out),  64'(8'h01 << e3));
            chk($sformatf("c_walk%0d.wrap", i), 64'(c_wrap), 64'(e3 == 3'd0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
